// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: word geometry and
// the loader FSM state encoding.
package mips_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Byte-to-word packer: counts accepted bytes and shifts them in MSB first.
// word_done pulses combinationally on the byte that completes a word, and
// word then presents the fully assembled big-endian value for that same edge.
module byte_packer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        in_data,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-9:0] shift;

  assign word      = {shift, in_data};
  assign word_done = accept && (cnt == CNT_W'(BYTES_PER_WORD - 1));

  // Byte counter (wraps naturally after the last byte) and shift register of earlier bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      shift <= '0;
    end else if (clear) begin
      cnt   <= '0;
      shift <= '0;
    end else if (accept) begin
      cnt   <= cnt + CNT_W'(1);
      shift <= word[WORD_W-9:0];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader. Receives a byte stream (word count, then the
// program words, all big-endian), writes each word to consecutive word
// addresses from BASE_ADDR and holds the core in reset until a clean load.
// Optional trailing XOR checksum word: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int               IDX_W = $clog2(MAX_WORDS + 1);
  localparam logic [WORD_W-1:0] MAX_N = WORD_W'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t END_STATE = CHK;
`else
  localparam loader_state_t END_STATE = DONE;
`endif

  loader_state_t     state;
  loader_state_t     next_state;
  logic              accept;
  logic              restart;
  logic              data_write;
  logic [WORD_W-1:0] word;
  logic              word_done;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_inc;
  logic [IDX_W-1:0]  n_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] acc;
`endif

  assign in_ready = (state == LEN) || (state == DATA) || (state == CHK);
  assign cpu_hold = (state != DONE);
  assign done     = (state == DONE);
  assign error    = (state == ERR);
  assign accept   = in_valid && in_ready;
  assign idx_inc  = idx + IDX_W'(1);

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (restart),
    .accept    (accept),
    .in_data   (in_data),
    .word      (word),
    .word_done (word_done)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the restart and data-write strobes it implies.
  always_comb begin
    next_state = state;
    restart    = 1'b0;
    data_write = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = LEN;
          restart    = 1'b1;
        end
      end
      LEN: begin
        if (word_done) begin
          if (word == '0) begin
            next_state = END_STATE;
          end else if (word > MAX_N) begin
            next_state = ERR;
          end else begin
            next_state = DATA;
          end
        end
      end
      DATA: begin
        if (word_done) begin
          data_write = 1'b1;
          if (idx_inc == n_words) begin
            next_state = END_STATE;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (word_done) begin
          next_state = (word == acc) ? DONE : ERR;
        end
      end
`endif
      DONE, ERR: begin
        if (start) begin
          next_state = LEN;
          restart    = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Word index, captured length and the registered memory write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      n_words   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      mem_we <= data_write;
      if (restart) begin
        idx <= '0;
      end else if (data_write) begin
        idx <= idx_inc;
      end
      if ((state == LEN) && word_done) begin
        n_words <= word[IDX_W-1:0];
      end
      if (data_write) begin
        mem_addr  <= BASE_ADDR + 32'(idx);
        mem_wdata <= word;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of every data word, compared against the trailing word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (restart) begin
      acc <= '0;
    end else if (data_write) begin
      acc <= acc ^ word;
    end
  end
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory read by the MIPS core. It receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written to consecutive word addresses starting at a base address. The core is held in reset until a load completes cleanly. The loader sits between an external byte source (UART/JTAG bridge) and the instruction memory write port, beside the core.

## Interface
- `BASE_ADDR`, default 0: word address of the first program word. The core PC is word-indexed (+1 per instruction).
- `MAX_WORDS`, default 256: largest word count accepted in the header.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low. Every register clears immediately on assertion.
- `start` input, 1 bit: one-cycle pulse that begins a load.
- `in_data` input, 8 bits: stream byte.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: loader accepts a byte this cycle.
- `mem_addr` output, 32 bits: instruction memory word address.
- `mem_wdata` output, 32 bits: word to write.
- `mem_we` output, 1 bit: single-cycle write strobe.
- `cpu_hold` output, 1 bit: drives the core's reset while high.
- `done` output, 1 bit: load finished without error (level).
- `error` output, 1 bit: load aborted (level).

## Operation
- Stream format: 4-byte word count N, MSB first; then N words, each MSB first; then an optional checksum word (see Configuration).
- A byte is accepted when `in_valid & in_ready` at a rising edge.
- States and transitions:
  - IDLE: `start` → LEN.
  - LEN: collect 4 bytes into N.
    - N == 0 → DONE (or CHK when the checksum is enabled).
    - N > MAX_WORDS → ERR.
    - Otherwise → DATA.
  - DATA: collect words.
    - After each 4th byte, issue a write to `BASE_ADDR + idx`, then idx++.
    - After word N → DONE (or CHK when the checksum is enabled).
  - CHK: collect the checksum word. Match → DONE; mismatch → ERR.
  - DONE or ERR: `start` → LEN. idx, byte counter and checksum accumulator are cleared.
- `start` in LEN, DATA or CHK is ignored.
- `in_ready` = 1 only in LEN, DATA and CHK.
- `cpu_hold` = 0 only in DONE. It is 1 in IDLE, LEN, DATA, CHK and ERR.
- A restart from DONE raises `cpu_hold` again on the cycle after `start`.
- Byte counter is 2 bits and wraps 3→0. The shift register is `{word[23:0], in_data}`.
- idx width is clog2(MAX_WORDS+1). Address arithmetic is 32-bit unsigned and wraps modulo 2^32.

## Timing
- Reset values: `in_ready`=0, `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `cpu_hold`=1, `done`=0, `error`=0. State = IDLE.
- `start` sampled at edge t → `in_ready`=1 from cycle t+1.
- 4th byte of a data word accepted at edge t → registered `mem_we`=1 for exactly cycle t+1. `mem_addr` and `mem_wdata` are valid in that same cycle and hold until the next write.
- Write latency is 1 cycle. Full throughput is one byte per cycle.
- The last data word's `mem_we` coincides with the first cycle of DONE or CHK.
- `done` or `error` rise on the cycle after the final byte is accepted. They stay high until the next `start` or reset.
- Reset asserted mid-load: the partial word is discarded, no further `mem_we` is issued, and `cpu_hold`=1 immediately. Memory contents already written are not rolled back.
- `in_valid` low stalls the FSM with no timeout. Bytes offered while `in_ready`=0 are not consumed.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The CHK state exists.
  - The accumulator is the XOR of all N data words, starting from 0.
  - The trailing word must equal the accumulator, otherwise ERR with `cpu_hold` staying 1.
- Undefined:
  - No CHK state and no accumulator logic.
  - The stream ends after word N.
  - `error` is raised only for N > MAX_WORDS.

## Structure
- Shared package `mips_pkg`:
  - loader state enum (IDLE, LEN, DATA, CHK, DONE, ERR)
  - `WORD_W`=32
  - `BYTES_PER_WORD`=4
- Sub-module `byte_packer`: byte counter, shift register and word-complete pulse. Reused for the LEN, DATA and CHK phases.
- The FSM, index counter and checksum stay in `imem_loader`.

## Test plan
- Basic load:
  - Stimulus: reset, `start`, stream 00 00 00 02 | 20 01 00 05 | 00 22 18 20 at one byte per cycle, BASE_ADDR=0.
  - Response: two `mem_we` pulses, at (0, 0x20010005) and (1, 0x00221820). Then `done`=1 and `cpu_hold`=0.
- Backpressure gaps:
  - Stimulus: same stream with random `in_valid` gaps.
  - Response: identical writes. Each `mem_we` is exactly 1 cycle, one cycle after the 4th byte.
- Limit check:
  - Stimulus: header N=257 with MAX_WORDS=256.
  - Response: no `mem_we`, `error`=1, `cpu_hold`=1, `in_ready`=0.
- Zero-length and restart:
  - Stimulus: N=0 with the checksum disabled.
  - Response: `done` on the cycle after the 4th header byte.
  - Follow-up: `start` again, then load 1 word (0xDEADBEEF) at BASE_ADDR=0x100.
  - Response: write at address 0x100.
- Mid-load reset:
  - Stimulus: assert `reset` after 2 bytes of word 1.
  - Response: immediate reset values, no write. A subsequent full load succeeds.
- Checksum (with `IMEM_LOADER_CHECKSUM_EN`):
  - Stimulus: words 0x12345678 and 0x0F0F0F0F followed by checksum 0x1D3B5977.
  - Response: `done`.
  - Stimulus: same words followed by checksum 0x00000000.
  - Response: `error`=1 and `cpu_hold` stays 1.
